// File: rtl/obtc_pkg.sv
// Shared OBTC definitions: datapath widths, beat count and the packer FSM states.
package obtc_pkg;

  localparam int HASH_W = 256;
  localparam int WORD_W = 64;
  localparam int BEATS  = 4;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_SEND    = 1'b1
  } state_t;

endpackage

// File: rtl/heavy_xor_packer_if.sv
// Bundle of the three handshake channels around the heavy-XOR packer:
// reference hash in, matrix product words in, packed result out.
interface heavy_xor_packer_if;
  import obtc_pkg::*;

  logic              hash_in_valid;
  logic              hash_in_ready;
  logic [HASH_W-1:0] hash_in_data;

  logic              prod_valid;
  logic              prod_ready;
  logic [WORD_W-1:0] prod_data;

  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_data;

  logic [BEAT_W-1:0] beat_cnt;

  modport slave (
    input  hash_in_valid, hash_in_data, prod_valid, prod_data, out_ready,
    output hash_in_ready, prod_ready, out_valid, out_data, beat_cnt
  );

  modport master (
    output hash_in_valid, hash_in_data, prod_valid, prod_data, out_ready,
    input  hash_in_ready, prod_ready, out_valid, out_data, beat_cnt
  );

endinterface

// File: rtl/hash_ref_fifo.sv
// First-word-fall-through FIFO holding reference hashes; head is visible on dout
// whenever empty is low. Pointers carry one extra wrap bit to tell full from empty.
module hash_ref_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty masks stale entries.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset drops every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/heavy_xor_packer.sv
// Collects four 64-bit matrix-product words into a 256-bit word and, when the
// OBTC_HEAVY_XOR_EN macro is defined, XORs it with the oldest queued reference
// hash. Without the macro the packed product is forwarded as-is, but the
// reference queue still pairs one hash with each result.
//
//   state     | meaning
//   S_COLLECT | accepting product words (only while a reference hash is queued)
//   S_SEND    | result registered, holding out_valid until downstream accepts
module heavy_xor_packer
  import obtc_pkg::*;
#(
  parameter int REF_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  heavy_xor_packer_if.slave bus
);

  state_t                   state_q;
  state_t                   state_d;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [HASH_W-1:0]        fifo_head;
  logic                     hash_push;
  logic                     prod_ready_c;
  logic                     prod_fire;
  logic                     out_fire;
  logic                     last_beat;
  logic [HASH_W-WORD_W-1:0] acc;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [HASH_W-1:0]        prod_packed;
  logic [HASH_W-1:0]        result;
  logic [HASH_W-1:0]        out_data_q;
  logic                     out_valid_q;

  assign bus.hash_in_ready = !rst && !fifo_full;
  assign hash_push         = bus.hash_in_valid && bus.hash_in_ready;
  assign prod_fire         = bus.prod_valid && prod_ready_c;
  assign out_fire          = out_valid_q && bus.out_ready;
  assign last_beat         = (beat_cnt == BEAT_W'(BEATS-1));

  hash_ref_fifo #(
    .W     (HASH_W),
    .DEPTH (REF_DEPTH)
  ) u_ref_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hash_push),
    .din   (bus.hash_in_data),
    .pop   (out_fire),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The final word goes straight into the result, so acc only keeps the earlier beats.
  assign prod_packed = {acc, bus.prod_data};

`ifdef OBTC_HEAVY_XOR_EN
  assign result = prod_packed ^ fifo_head;
`else
  logic unused_head;
  assign unused_head = ^fifo_head;
  assign result      = prod_packed;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and product-channel ready; words are refused while no hash is queued.
  always_comb begin
    state_d      = state_q;
    prod_ready_c = 1'b0;
    case (state_q)
      S_COLLECT: begin
        prod_ready_c = !rst && !fifo_empty;
        if (bus.prod_valid && prod_ready_c && last_beat) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_fire) begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Beat collection, result register and output-valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      beat_cnt    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (prod_fire) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        for (int k = 0; k < BEATS-1; k++) begin
          if (beat_cnt == BEAT_W'(k)) begin
            acc[(HASH_W-WORD_W-1) - WORD_W*k -: WORD_W] <= bus.prod_data;
          end
        end
        if (last_beat) begin
          out_data_q  <= result;
          out_valid_q <= 1'b1;
        end
      end
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.prod_ready = prod_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.beat_cnt   = beat_cnt;

endmodule

// File: tb/tb_heavy_xor_packer.sv
// Scoreboard bench for heavy_xor_packer: drivers push expected results into a
// queue from a transaction-level model, a monitor pops and compares on handshake.
module tb_heavy_xor_packer;
  import obtc_pkg::*;

`ifdef OBTC_HEAVY_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  heavy_xor_packer_if bus ();

  heavy_xor_packer #(.REF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [255:0] hash_q [$];
  logic [255:0] exp_q  [$];
  logic [63:0]  word_q [$];
  bit           stim_done;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur within its bound", name);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  // Transaction model: every 4 accepted words form word0..word3 MSB-first and
  // pair with the oldest hash accepted so far.
  task automatic model_word(input logic [63:0] w);
    logic [255:0] p;
    logic [255:0] h;
    word_q.push_back(w);
    if (word_q.size() == 4) begin
      p = {word_q[0], word_q[1], word_q[2], word_q[3]};
      if (hash_q.size() == 0) begin
        fail("pairing_hash_available");
        h = '0;
      end else begin
        h = hash_q.pop_front();
      end
      exp_q.push_back(XOR_EN ? (p ^ h) : p);
      word_q.delete();
    end
  endtask

  task automatic model_reset();
    hash_q.delete();
    word_q.delete();
    exp_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_hash(input logic [255:0] h);
    int n = 0;
    bit done = 0;
    bus.hash_in_valid = 1'b1;
    bus.hash_in_data  = h;
    while (!done && n < 300) begin
      #1;
      if (bus.hash_in_ready) begin
        hash_q.push_back(h);
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    bus.hash_in_valid = 1'b0;
    if (!done) fail("hash_push_timeout");
  endtask

  task automatic send_word(input logic [63:0] w);
    int n = 0;
    bit done = 0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = w;
    while (!done && n < 300) begin
      #1;
      if (bus.prod_ready) begin
        model_word(w);
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    bus.prod_valid = 1'b0;
    if (!done) fail("prod_word_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("result_drain_timeout");
    @(negedge clk);
  endtask

  // Monitor: compares each handshaken result with the scoreboard head and
  // requires out_valid/out_data to stay put while downstream stalls.
  initial begin : monitor
    logic         hold;
    logic [255:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk1("hold_out_valid", bus.out_valid, 1'b1);
          chk("hold_out_data", bus.out_data, held);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) fail("result_without_expectation");
          else chk("result", bus.out_data, exp_q.pop_front());
          hold = 1'b0;
        end else if (bus.out_valid) begin
          hold = 1'b1;
          held = bus.out_data;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] cat;
    logic [255:0] req33;

    bus.hash_in_valid = 1'b0;
    bus.hash_in_data  = '0;
    bus.prod_valid    = 1'b0;
    bus.prod_data     = '0;
    bus.out_ready     = 1'b0;
    stim_done         = 1'b0;
    rst               = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_hash_in_ready", bus.hash_in_ready, 1'b0);
    chk1("rst_prod_ready", bus.prod_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk_i("rst_beat_cnt", int'(bus.beat_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("idle_hash_in_ready", bus.hash_in_ready, 1'b1);
    @(negedge clk);

    // Product words offered with no reference hash are refused
    bus.prod_valid = 1'b1;
    bus.prod_data  = rnd64();
    repeat (4) begin
      #1;
      chk1("empty_prod_ready", bus.prod_ready, 1'b0);
      chk_i("empty_beat_cnt", int'(bus.beat_cnt), 0);
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;

    // First hash opens the product channel
    push_hash('0);
    #1;
    chk1("first_prod_ready", bus.prod_ready, 1'b1);
    chk1("first_out_valid", bus.out_valid, 1'b0);
    chk("first_out_data", bus.out_data, '0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (4) send_word(rnd64());
    wait_drain();

    // Known-answer transaction, then a 10-cycle downstream stall
    bus.out_ready = 1'b0;
    push_hash({256{1'b1}});
    send_word(64'h0123456789ABCDEF);
    send_word(64'h0);
    send_word(64'hFFFFFFFFFFFFFFFF);
    send_word(64'h1);
    cat   = {64'h0123456789ABCDEF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1};
    req33 = XOR_EN ? ~cat : cat;
    #1;
    chk1("kat_out_valid_latency", bus.out_valid, 1'b1);
    chk("kat_out_data", bus.out_data, req33);
    chk1("send_hash_in_ready", bus.hash_in_ready, 1'b1);
    @(negedge clk);
    push_hash(rnd256());
    repeat (9) begin
      #1;
      chk1("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_out_data", bus.out_data, req33);
      chk1("stall_prod_ready", bus.prod_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    repeat (4) send_word(rnd64());
    wait_drain();

    // Queue full: third hash stalls until the first result handshakes
    bus.out_ready = 1'b0;
    push_hash(rnd256());
    push_hash(rnd256());
    #1;
    chk1("full_hash_in_ready", bus.hash_in_ready, 1'b0);
    @(negedge clk);
    repeat (4) send_word(rnd64());
    repeat (3) begin
      #1;
      chk1("full_stall_hash_in_ready", bus.hash_in_ready, 1'b0);
      chk1("full_stall_out_valid", bus.out_valid, 1'b1);
      @(negedge clk);
    end
    fork
      push_hash(rnd256());
      begin
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    repeat (8) send_word(rnd64());
    wait_drain();

    // Reset after beat 2 discards the partial product and the queued hash
    push_hash(rnd256());
    repeat (3) send_word(rnd64());
    rst = 1'b1;
    model_reset();
    #1;
    chk1("midrst_hash_in_ready", bus.hash_in_ready, 1'b0);
    chk1("midrst_prod_ready", bus.prod_ready, 1'b0);
    @(negedge clk);
    #1;
    chk_i("midrst_beat_cnt", int'(bus.beat_cnt), 0);
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("postrst_prod_ready", bus.prod_ready, 1'b0);
    chk1("postrst_hash_in_ready", bus.hash_in_ready, 1'b1);
    @(negedge clk);
    push_hash(rnd256());
    repeat (4) send_word(rnd64());
    wait_drain();

    // Random traffic on all three channels
    fork
      begin
        fork
          for (int i = 0; i < 25; i++) begin
            push_hash(rnd256());
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
          for (int j = 0; j < 100; j++) begin
            send_word(rnd64());
            repeat ($urandom_range(0, 1)) @(negedge clk);
          end
        join
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk_i("final_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/heavy_xor_packer.md
HEAVY_XOR_PACKER -- requirements
Module: heavy_xor_packer

Interface
REQ-001 SHALL expose parameter REF_DEPTH, default 2, depth of the reference-hash queue (power of two, at least 2).
REQ-002 SHALL have input clk, 1 bit: global clock, all state on rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input hash_in_valid, 1 bit: original 256-bit hash offered.
REQ-005 SHALL have output hash_in_ready, 1 bit: reference queue can accept.
REQ-006 SHALL have input hash_in_data, 256 bits: original hash, bit 255 = first nibble MSB.
REQ-007 SHALL have input prod_valid, 1 bit: matrix-product word offered by the matrix datapath.
REQ-008 SHALL have output prod_ready, 1 bit: product word accepted this cycle.
REQ-009 SHALL have input prod_data, 64 bits: one product word (16 nibbles, PE outputs 16k..16k+15, MSB first).
REQ-010 SHALL have output out_valid, 1 bit: packed result available.
REQ-011 SHALL have input out_ready, 1 bit: downstream (keccak stage) accepts result.
REQ-012 SHALL have output out_data, 256 bits: packed result.
REQ-013 SHALL have output beat_cnt, 2 bits: index of next expected product word.

Function
REQ-014 SHALL transfer on any interface only when valid and ready are both high at a rising edge.
REQ-015 SHALL drive hash_in_ready = not rst and queue not full; a push while full SHALL NOT occur, regardless of a same-cycle pop.
REQ-016 SHALL, when push and pop coincide on a non-full queue, perform both and keep occupancy unchanged.
REQ-017 SHALL implement an FSM with states S_COLLECT and S_SEND.
REQ-018 In S_COLLECT, SHALL drive prod_ready = queue not empty; in S_SEND, prod_ready = 0.
REQ-019 SHALL store accepted word k (k = beat_cnt) into acc bits [255-64k : 192-64k]; beat_cnt SHALL increment modulo 4 on each accepted word.
REQ-020 SHALL, on acceptance of word 3, register out_data = {acc[255:64], prod_data} XOR queue head, set out_valid, and enter S_SEND the next cycle (latency 1 cycle from final beat).
REQ-021 In S_SEND, SHALL hold out_valid and out_data stable until out_ready is high.
REQ-022 SHALL, on out_valid and out_ready, pop the queue head, clear out_valid, return to S_COLLECT with beat_cnt = 0.
REQ-023 SHALL never accept product words while the queue is empty, so every result pairs with exactly one reference hash, in FIFO order.
REQ-024 SHALL leave out_data unchanged after handshake until the next result is registered.

Reset
REQ-025 SHALL, while rst is high at an edge, set: state S_COLLECT, beat_cnt 0, acc 0, out_data 0, out_valid 0, queue empty.
REQ-026 SHALL drive hash_in_ready 0 and prod_ready 0 while rst is high.
REQ-027 SHALL discard any partially collected product and all queued hashes when reset is asserted mid-operation.

Configuration
REQ-028 With OBTC_HEAVY_XOR_EN defined, SHALL XOR the packed product with the reference hash as in REQ-020.
REQ-029 Without OBTC_HEAVY_XOR_EN, out_data SHALL equal the packed product; the reference queue, handshake and pairing rules SHALL remain unchanged.

Structure
REQ-030 SHALL take HASH_W=256, WORD_W=64, BEATS=4 and the FSM state enum from shared package obtc_pkg.
REQ-031 SHALL implement the reference queue as sub-module hash_ref_fifo: synchronous, first-word-fall-through, parameterised width and depth, with full and empty outputs.

Verification
REQ-032 Reset then push hash 0 -> hash_in_ready=1, prod_ready=1 next cycle, out_valid=0, out_data=0.
REQ-033 Hash all-ones, words 0x0123456789ABCDEF, 0x0, 0xFFFFFFFFFFFFFFFF, 0x1 -> one cycle after beat 3, out_valid=1, out_data = bitwise inverse of the 4 words concatenated (without the macro: the concatenation itself).
REQ-034 prod_valid high with queue empty -> prod_ready=0 and beat_cnt stays 0 until a hash is pushed.
REQ-035 out_ready held low 10 cycles in S_SEND -> out_valid and out_data stable, prod_ready=0, a second hash is still accepted while the queue is not full.
REQ-036 REF_DEPTH=2, push 3 hashes back-to-back -> third stalls (hash_in_ready=0) until the first result handshakes; results are emitted in push order.
REQ-037 rst asserted after beat 2 -> beat_cnt=0, queue empty, out_valid=0; a following full transaction yields the correct result.
